// File: rtl/dfe_out_fifo_if.sv
// dfe_out_fifo_if: sample handshake, stats control and status bundle of the decimator output FIFO
interface dfe_out_fifo_if #(
    parameter int DATA_WIDTH     = 16,
    parameter int DEPTH          = 16,
    parameter int DROP_CNT_WIDTH = 8
);
    logic                      valid_in;
    logic [DATA_WIDTH-1:0]     data_in;
    logic                      out_ready;
    logic                      out_valid;
    logic [DATA_WIDTH-1:0]     out_data;
    logic                      clr_stats;
    logic [$clog2(DEPTH):0]    level;
    logic                      almost_full;
    logic                      full;
    logic                      drop_sticky;
    logic [DROP_CNT_WIDTH-1:0] drop_count;
    modport master (
        output valid_in, data_in, out_ready, clr_stats,
        input  out_valid, out_data, level, almost_full, full, drop_sticky, drop_count
    );
    modport slave (
        input  valid_in, data_in, out_ready, clr_stats,
        output out_valid, out_data, level, almost_full, full, drop_sticky, drop_count
    );
endinterface

// File: rtl/dfe_out_fifo.sv
// dfe_out_fifo: first-word fall-through output buffer with drop-on-full accounting
module dfe_out_fifo #(
    parameter int DATA_WIDTH     = 16,
    parameter int DEPTH          = 16,
    parameter int AFULL_THRESH   = 12,
    parameter int DROP_CNT_WIDTH = 8
) (
    input logic           clk,
    input logic           rst,
    dfe_out_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [DATA_WIDTH-1:0]     mem_q [DEPTH];
    logic [AW-1:0]             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]             level_q, level_d;
    logic                      full_q, full_d, afull_q, afull_d, sticky_q, sticky_d;
    logic [DROP_CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                      push, pop, drop, not_empty;

    always_comb begin
        not_empty = level_q != '0;
        pop       = not_empty && bus.out_ready;
        push      = bus.valid_in && (!full_q || pop);
        drop      = bus.valid_in && full_q && !pop;
        wr_ptr_d  = wr_ptr_q + AW'(push);
        rd_ptr_d  = rd_ptr_q + AW'(pop);
        level_d   = level_q + LW'(push) - LW'(pop);
        full_d    = level_d == LW'(DEPTH);
        afull_d   = level_d >= LW'(AFULL_THRESH);
        sticky_d  = drop || (sticky_q && !bus.clr_stats);
        // a drop coinciding with a clear counts as the first loss after the clear
        cnt_d     = bus.clr_stats ? DROP_CNT_WIDTH'(drop)
                  : (drop && cnt_q != '1) ? cnt_q + DROP_CNT_WIDTH'(1) : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            afull_q  <= 1'b0;
            sticky_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= full_d;
            afull_q  <= afull_d;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= bus.data_in;
    end

    assign bus.out_valid   = not_empty;
    assign bus.out_data    = not_empty ? mem_q[rd_ptr_q] : '0;
    assign bus.level       = level_q;
    assign bus.full        = full_q;
    assign bus.almost_full = afull_q;
    assign bus.drop_sticky = sticky_q;
    assign bus.drop_count  = cnt_q;
endmodule
